// File: rtl/comparator_nbit_seq.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock MSB-first with early exit.
// Latency 1..WIDTH/CHUNK cycles after the accepting edge; start is ignored while busy.
module comparator_nbit_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic {IDLE, CMP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             done_q, done_d;
   logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
   logic [CHUNK-1:0] ca, cb;

   // Operands shift left as chunks match, so the active chunk is always the top one.
   assign ca = a_q[WIDTH-1 -: CHUNK];
   assign cb = b_q[WIDTH-1 -: CHUNK];

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               // Offset-binary mapping turns a signed compare into an unsigned one.
               a_d            = a;
               b_d            = b;
               a_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
               b_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
               idx_d          = IW'(NCHUNK - 1);
               state_d        = CMP;
            end
         end
         CMP: begin
            if (ca != cb) begin
               gt_d    = (ca > cb);
               lt_d    = (ca < cb);
               eq_d    = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (idx_q == '0) begin
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d = idx_q - IW'(1);
               a_d   = a_q << CHUNK;
               b_d   = b_q << CHUNK;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
      end
   end

   assign busy = (state_q == CMP);
   assign done = done_q;
   assign gt   = gt_q;
   assign eq   = eq_q;
   assign lt   = lt_q;

endmodule

// File: tb/tb_comparator_nbit_seq.sv
// Directed and random checks of comparator_nbit_seq at 16/4, 8/8 and 8/1.
module tb_comparator_nbit_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // 16-bit, 4-bit chunk instance
   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16, gt16, eq16, lt16;
   logic [2:0]  f16;
   assign f16 = {gt16, eq16, lt16};

   comparator_nbit_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .signed_mode(sm16),
      .busy(busy16), .done(done16), .gt(gt16), .eq(eq16), .lt(lt16));

   // 8-bit instances share operand inputs, separate starts
   logic       st8a = 1'b0, st8b = 1'b0, sm8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8a, done8a, gt8a, eq8a, lt8a;
   logic       busy8b, done8b, gt8b, eq8b, lt8b;

   comparator_nbit_seq #(.WIDTH(8), .CHUNK(8)) dut8a (
      .clk(clk), .rst(rst), .start(st8a), .a(a8), .b(b8), .signed_mode(sm8),
      .busy(busy8a), .done(done8a), .gt(gt8a), .eq(eq8a), .lt(lt8a));

   comparator_nbit_seq #(.WIDTH(8), .CHUNK(1)) dut8b (
      .clk(clk), .rst(rst), .start(st8b), .a(a8), .b(b8), .signed_mode(sm8),
      .busy(busy8b), .done(done8b), .gt(gt8b), .eq(eq8b), .lt(lt8b));

   // Runs one compare on the 16-bit instance; lat = edges from E0 to done.
   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        output int lat, output logic [2:0] fl, output bit bok);
      @(negedge clk);
      a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      bok = 1'b1;
      while (!done16 && lat < 20) begin
         if (!busy16) bok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy16) bok = 1'b0;
      fl = f16;
   endtask

   task automatic run8(input bit which, input logic [7:0] av, input logic [7:0] bv,
                       input logic sm, output int lat, output logic [2:0] fl);
      @(negedge clk);
      a8 = av; b8 = bv; sm8 = sm;
      if (which) st8b = 1'b1; else st8a = 1'b1;
      @(negedge clk);
      st8a = 1'b0; st8b = 1'b0;
      lat = 0;
      while (!(which ? done8b : done8a) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      fl = which ? {gt8b, eq8b, lt8b} : {gt8a, eq8a, lt8a};
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({busy16, done16, f16} !== 5'b0)
         $display("FAIL reset_outputs: got %b want 00000", {busy16, done16, f16});
      else passed++;
      checks++;
      if ({busy8a, done8a, gt8a, eq8a, lt8a, busy8b, done8b, gt8b, eq8b, lt8b} !== 10'b0)
         $display("FAIL reset_outputs8: got %b want 0", {busy8a, busy8b, gt8a, eq8a, lt8a});
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat; logic [2:0] fl; bit bok; bit saw_done;
      @(negedge clk);
      a16 = 16'h1234; b16 = 16'h1234; sm16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy16 !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy16);
      else passed++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy16, done16, f16} !== 5'b0)
         $display("FAIL mid_reset_async: got %b want 00000", {busy16, done16, f16});
      else passed++;
      saw_done = 1'b0;
      repeat (2) begin @(negedge clk); if (done16) saw_done = 1'b1; end
      rst = 1'b0;
      repeat (4) begin @(negedge clk); if (done16 || busy16) saw_done = 1'b1; end
      checks++;
      if (saw_done !== 1'b0) $display("FAIL mid_no_done: got activity=%b want 0", saw_done);
      else passed++;
      run16(16'h1234, 16'h1234, 1'b0, lat, fl, bok);
      checks++;
      if (fl !== 3'b010 || lat != 4)
         $display("FAIL mid_rerun: got flags=%b lat=%0d want 010 lat=4", fl, lat);
      else passed++;
   endtask

   task automatic test_equal();
      int lat; logic [2:0] fl; bit bok;
      run16(16'h0000, 16'h0000, 1'b0, lat, fl, bok);
      checks++;
      if (fl !== 3'b010) $display("FAIL equal_flags: got %b want 010", fl); else passed++;
      checks++;
      if (lat != 4) $display("FAIL equal_latency: got %0d want 4", lat); else passed++;
      checks++;
      if (bok !== 1'b1) $display("FAIL equal_busy: got busy_ok=%b want 1", bok); else passed++;
      @(negedge clk);
      checks++;
      if (done16 !== 1'b0) $display("FAIL equal_done_pulse: got %b want 0", done16);
      else passed++;
   endtask

   task automatic test_early_exit();
      int lat; logic [2:0] fl; bit bok;
      run16(16'h5000, 16'h3FFF, 1'b0, lat, fl, bok);
      checks++;
      if (fl !== 3'b100 || lat != 1)
         $display("FAIL early_msb: got flags=%b lat=%0d want 100 lat=1", fl, lat);
      else passed++;
      run16(16'h1235, 16'h1237, 1'b0, lat, fl, bok);
      checks++;
      if (fl !== 3'b001 || lat != 4 || !bok)
         $display("FAIL early_lsb: got flags=%b lat=%0d want 001 lat=4", fl, lat);
      else passed++;
   endtask

   task automatic test_signed();
      int lat; logic [2:0] fl; bit bok;
      run16(16'hFFFF, 16'h0001, 1'b1, lat, fl, bok);
      checks++;
      if (fl !== 3'b001 || lat != 1)
         $display("FAIL signed_neg1_vs_1: got flags=%b lat=%0d want 001 lat=1", fl, lat);
      else passed++;
      run16(16'hFFFF, 16'h0001, 1'b0, lat, fl, bok);
      checks++;
      if (fl !== 3'b100 || lat != 1)
         $display("FAIL unsigned_ffff_vs_1: got flags=%b lat=%0d want 100 lat=1", fl, lat);
      else passed++;
      run16(16'h8000, 16'h7FFF, 1'b1, lat, fl, bok);
      checks++;
      if (fl !== 3'b001 || lat != 1)
         $display("FAIL signed_min_vs_max: got flags=%b lat=%0d want 001 lat=1", fl, lat);
      else passed++;
   endtask

   task automatic test_ignored_start();
      int lat;
      @(negedge clk);
      a16 = 16'hAAAA; b16 = 16'hAAAB; sm16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; end
         if (lat == 2) begin start16 = 1'b0; a16 = 16'h1234; end
      end
      checks++;
      if (f16 !== 3'b001 || lat != 4)
         $display("FAIL ignored_start: got flags=%b lat=%0d want 001 lat=4", f16, lat);
      else passed++;
      @(negedge clk);
      checks++;
      if (busy16 !== 1'b0) $display("FAIL ignored_no_restart: got busy=%b want 0", busy16);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lat; bit hold_ok;
      @(negedge clk);
      a16 = 16'h1235; b16 = 16'h1237; sm16 = 1'b0; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (f16 !== 3'b001) $display("FAIL b2b_first: got %b want 001", f16); else passed++;
      a16 = 16'h0001; b16 = 16'h0000; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      checks++;
      if (busy16 !== 1'b1) $display("FAIL b2b_no_gap: got busy=%b want 1", busy16);
      else passed++;
      lat = 0;
      hold_ok = 1'b1;
      while (!done16 && lat < 20) begin
         if (f16 !== 3'b001) hold_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (hold_ok !== 1'b1) $display("FAIL b2b_flags_hold: got hold=%b want 1", hold_ok);
      else passed++;
      checks++;
      if (f16 !== 3'b100 || lat != 4)
         $display("FAIL b2b_second: got flags=%b lat=%0d want 100 lat=4", f16, lat);
      else passed++;
   endtask

   task automatic test_sweep();
      int lat; logic [2:0] fl;
      run8(1'b0, 8'h12, 8'h34, 1'b0, lat, fl);
      checks++;
      if (fl !== 3'b001 || lat != 1)
         $display("FAIL w8c8_lt: got flags=%b lat=%0d want 001 lat=1", fl, lat);
      else passed++;
      run8(1'b0, 8'h55, 8'h55, 1'b0, lat, fl);
      checks++;
      if (fl !== 3'b010 || lat != 1)
         $display("FAIL w8c8_eq: got flags=%b lat=%0d want 010 lat=1", fl, lat);
      else passed++;
      run8(1'b0, 8'h80, 8'h7F, 1'b1, lat, fl);
      checks++;
      if (fl !== 3'b001 || lat != 1)
         $display("FAIL w8c8_signed: got flags=%b lat=%0d want 001 lat=1", fl, lat);
      else passed++;
      run8(1'b1, 8'hA5, 8'hA5, 1'b0, lat, fl);
      checks++;
      if (fl !== 3'b010 || lat != 8)
         $display("FAIL w8c1_eq: got flags=%b lat=%0d want 010 lat=8", fl, lat);
      else passed++;
      run8(1'b1, 8'h80, 8'h7F, 1'b0, lat, fl);
      checks++;
      if (fl !== 3'b100 || lat != 1)
         $display("FAIL w8c1_gt: got flags=%b lat=%0d want 100 lat=1", fl, lat);
      else passed++;
      run8(1'b1, 8'hA4, 8'hA5, 1'b1, lat, fl);
      checks++;
      if (fl !== 3'b001 || lat != 8)
         $display("FAIL w8c1_lsb: got flags=%b lat=%0d want 001 lat=8", fl, lat);
      else passed++;
   endtask

   task automatic test_random();
      int lat; logic [2:0] fl, ex; bit bok;
      logic [15:0] ra, rb; logic [7:0] qa, qb; logic sm;
      for (int i = 0; i < 24; i++) begin
         ra = 16'($urandom);
         rb = (i % 4 == 0) ? ra : 16'($urandom);
         if (i % 6 == 1) rb = {ra[15:4], 4'($urandom)};
         sm = 1'($urandom);
         if (sm) ex = {$signed(ra) > $signed(rb), ra == rb, $signed(ra) < $signed(rb)};
         else    ex = {ra > rb, ra == rb, ra < rb};
         run16(ra, rb, sm, lat, fl, bok);
         checks++;
         if (fl !== ex || lat < 1 || lat > 4)
            $display("FAIL rand16_%0d: a=%h b=%h s=%b got %b lat=%0d want %b", i, ra, rb, sm, fl, lat, ex);
         else passed++;
      end
      for (int i = 0; i < 12; i++) begin
         qa = 8'($urandom);
         qb = (i % 3 == 0) ? qa : 8'($urandom);
         sm = 1'($urandom);
         if (sm) ex = {$signed(qa) > $signed(qb), qa == qb, $signed(qa) < $signed(qb)};
         else    ex = {qa > qb, qa == qb, qa < qb};
         run8(i[0], qa, qb, sm, lat, fl);
         checks++;
         if (fl !== ex)
            $display("FAIL rand8_%0d: a=%h b=%h s=%b got %b want %b", i, qa, qb, sm, fl, ex);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_equal();
      test_early_exit();
      test_signed();
      test_ignored_start();
      test_back_to_back();
      test_sweep();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
